// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-bus bundle between the MEM-stage LSU and memory.
// Request/grant phase plus a separate load-response phase.
interface mem_stage_lsu_if;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [3:0]  dbe;
    logic [31:0] dwdata;
    logic        dgnt;
    logic        drvalid;
    logic [31:0] drdata;

    modport master (
        output dreq, dwe, daddr, dbe, dwdata,
        input  dgnt, drvalid, drdata
    );

    modport slave (
        input  dreq, dwe, daddr, dbe, dwdata,
        output dgnt, drvalid, drdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a req/gnt/resp data bus.
// Optional LSU_MISALIGN_CHECK_EN suppresses misaligned halfword/word accesses.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        MisalignM,
    mem_stage_lsu_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] cnt;
    logic [31:0] rdata;
    logic        err_q;
    logic        mis_q;

    logic        acc;
    logic        is_st;
    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        sx;
    logic [1:0]  off;
    logic        mis;
    logic        tmo;
    logic        req;

    logic        cap;
    logic [31:0] cap_val;
    logic        err_d;
    logic        mis_d;

    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] fmt;

    // both enables high behaves as a store
    assign acc   = MemReadM | MemWriteM;
    assign is_st = MemWriteM;
    assign is_b  = (Funct3M[1:0] == 2'b00);
    assign is_h  = (Funct3M[1:0] == 2'b01);
    assign is_w  = ~is_b & ~is_h;
    assign sx    = ~Funct3M[2];
    assign off   = ALUResultM[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = (is_h & off[0]) | (is_w & (off != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign tmo = (cnt == 16'(TIMEOUT - 1));

    assign req = ~clr & (((state == IDLE) & acc & ~mis) | (state == REQ));

    // store lane selection and replication
    always_comb begin
        be = 4'b1111;
        wd = WriteDataM;
        unique case (1'b1)
            is_b: begin
                be = 4'b0001 << off;
                wd = {4{WriteDataM[7:0]}};
            end
            is_h: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{WriteDataM[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = WriteDataM;
            end
        endcase
    end

    assign bus.dreq   = req;
    assign bus.dwe    = req & is_st;
    assign bus.daddr  = req ? {ALUResultM[31:2], 2'b00} : 32'd0;
    assign bus.dbe    = req ? be : 4'b0000;
    assign bus.dwdata = req ? wd : 32'd0;

    assign ld_b = bus.drdata[{off, 3'b000} +: 8];
    assign ld_h = bus.drdata[{off[1], 4'b0000} +: 16];

    // load lane extraction and sign/zero extension
    always_comb begin
        fmt = bus.drdata;
        unique case (1'b1)
            is_b:    fmt = {{24{sx & ld_b[7]}}, ld_b};
            is_h:    fmt = {{16{sx & ld_h[15]}}, ld_h};
            default: fmt = bus.drdata;
        endcase
    end

    // next-state, capture and flag decisions
    always_comb begin
        state_d = state;
        cap     = 1'b0;
        cap_val = 32'd0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    if (mis) begin
                        state_d = DONE;
                        cap     = 1'b1;
                        mis_d   = 1'b1;
                    end else if (bus.dgnt) begin
                        state_d = is_st ? DONE : RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.dgnt) begin
                    state_d = is_st ? DONE : RESP;
                end else if (tmo) begin
                    state_d = DONE;
                    cap     = 1'b1;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                if (bus.drvalid) begin
                    state_d = DONE;
                    cap     = 1'b1;
                    cap_val = fmt;
                end else if (tmo) begin
                    state_d = DONE;
                    cap     = 1'b1;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, read-data register and one-cycle DONE flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            rdata <= 32'd0;
            err_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            state <= state_d;
            err_q <= err_d;
            mis_q <= mis_d;
            if (cap) begin
                rdata <= cap_val;
            end
        end
    end

    // wait counter restarts on each entry to REQ or RESP
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= 16'd0;
        end else if ((state_d == REQ || state_d == RESP) && state_d != state) begin
            cnt <= 16'd0;
        end else if (state == REQ || state == RESP) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt <= 16'd0;
        end
    end

    assign StallM    = acc & (state != DONE);
    assign ReadDataM = rdata;
    assign BusErrM   = err_q;
`ifdef LSU_MISALIGN_CHECK_EN
    assign MisalignM = mis_q;
`else
    assign MisalignM = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized accesses against a
// transaction-level model of stall length, bus lanes and load data.
module tb_mem_stage_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        BusErrM;
    logic        MisalignM;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .clr        (clr),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .BusErrM    (BusErrM),
        .MisalignM  (MisalignM),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_model = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(StallM), 32'd0);
        chk("idle_dreq", 32'(bus.dreq), 32'd0);
        step();
    endtask

    // One complete MEM-stage access; the slave grants after gw refused
    // cycles and answers loads rw cycles after the grant.
    task automatic access(input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdat, input int gw,
                          input int rw, input logic [31:0] rdat,
                          input bit stray);
        int          size, off, base, n_stall, n_req, w_stall, w_req;
        bit          ld, mis, gto, rto, done;
        logic [3:0]  w_be;
        logic [31:0] w_dw, w_fmt;
        longint      v;

        ld   = rd && !wr;
        off  = int'(addr % 4);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        base = (off / size) * size;
        mis  = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis  = (off % size) != 0;
`endif
        for (int k = 0; k < 4; k++) begin
            w_be[k] = (k >= base) && (k < base + size);
            w_dw[8*k +: 8] = wdat[8*(k % size) +: 8];
        end
        v = longint'(rdat >> (8 * base)) & ((longint'(1) << (8 * size)) - 1);
        if (size < 4 && !f3[2] && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        w_fmt = v[31:0];

        gto = !mis && (gw > T);
        rto = !mis && !gto && ld && (rw >= T);
        w_req   = mis ? 0 : gto ? T + 1 : gw + 1;
        w_stall = mis ? 1 : gto ? T + 1 :
                  gw + 1 + (ld ? (rto ? T : rw + 1) : 0);
        if (mis || gto || rto) rd_model = 32'd0;
        else if (ld) rd_model = w_fmt;

        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wdat;
        bus.drdata = rdat;
        n_stall = 0;
        n_req   = 0;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.dgnt    = (c == gw);
            bus.drvalid = (ld && c == gw + 1 + rw) || (stray && ld && c <= gw);
            @(negedge clk);
            if (c == 0 && w_req > 0) begin
                chk("dwe", 32'(bus.dwe), 32'(!ld));
                chk("daddr", bus.daddr, {addr[31:2], 2'b00});
                chk("dbe", 32'(bus.dbe), 32'(w_be));
                if (!ld) chk("dwdata", bus.dwdata, w_dw);
            end
            n_stall += int'(StallM);
            n_req   += int'(bus.dreq);
            if (!StallM) begin
                done = 1'b1;
                chk("stall_cycles", n_stall, w_stall);
                chk("dreq_cycles", n_req, w_req);
                chk("ReadDataM", ReadDataM, rd_model);
                chk("BusErrM", 32'(BusErrM), 32'(gto || rto));
                chk("MisalignM", 32'(MisalignM), 32'(mis));
            end
            step();
        end
        chk("access_done", 32'(done), 32'd1);
        bus.dgnt    = 1'b0;
        bus.drvalid = 1'b0;
    endtask

    initial begin
        bit       r, w;
        int       kind;

        clr        = 1'b1;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b010;
        ALUResultM = 32'h0000_0100;
        WriteDataM = 32'h1234_5678;
        bus.dgnt    = 1'b0;
        bus.drvalid = 1'b0;
        bus.drdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dreq", 32'(bus.dreq), 32'd0);
        chk("rst_daddr", bus.daddr, 32'd0);
        chk("rst_dbe", 32'(bus.dbe), 32'd0);
        chk("rst_ReadDataM", ReadDataM, 32'd0);
        chk("rst_BusErrM", 32'(BusErrM), 32'd0);
        chk("rst_MisalignM", 32'(MisalignM), 32'd0);
        MemReadM = 1'b0;
        step();
        clr = 1'b0;
        idle_cycle();

        // clr while waiting for a response, then a stray response
        MemReadM   = 1'b1;
        Funct3M    = 3'b010;
        ALUResultM = 32'h0000_0040;
        bus.dgnt   = 1'b1;
        step();
        bus.dgnt = 1'b0;
        clr      = 1'b1;
        #1;
        chk("clr_dreq", 32'(bus.dreq), 32'd0);
        @(negedge clk);
        chk("clr_ReadDataM", ReadDataM, 32'd0);
        step();
        clr         = 1'b0;
        MemReadM    = 1'b0;
        bus.drvalid = 1'b1;
        bus.drdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("clr_after_dreq", 32'(bus.dreq), 32'd0);
        chk("clr_after_stall", 32'(StallM), 32'd0);
        step();
        bus.drvalid = 1'b0;
        @(negedge clk);
        chk("clr_no_capture", ReadDataM, 32'd0);
        step();

        // directed cases
        access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 0, 0, 32'd0, 1'b0);
        access(1'b1, 1'b0, 3'b000, 32'h102, 32'd0, 2, 0, 32'h0080_FF00, 1'b0);
        access(1'b1, 1'b0, 3'b100, 32'h102, 32'd0, 2, 0, 32'h0080_FF00, 1'b1);
        access(1'b1, 1'b0, 3'b001, 32'h206, 32'd0, 0, 0, 32'h8001_1234, 1'b0);
        access(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 0, 0, 32'h8001_1234, 1'b0);
        access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 0, 50, 32'h1111_2222, 1'b0);
        access(1'b1, 1'b0, 3'b101, 32'h302, 32'd0, 1, 1, 32'hC3A5_7E01, 1'b0);
        access(1'b0, 1'b1, 3'b010, 32'h102, 32'hCAFE_F00D, 0, 0, 32'd0, 1'b0);
        access(1'b0, 1'b1, 3'b001, 32'h10E, 32'h0000_BEEF, 9, 0, 32'd0, 1'b0);
        access(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 0, 0, 32'h0000_F0F0, 1'b0);
        idle_cycle();

        // randomized mix, including timeouts and stray responses
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 3));
            r = (kind == 0) || (kind == 2);
            w = (kind != 0);
            if (kind == 3) begin
                idle_cycle();
                r = 1'b1;
                w = 1'b0;
            end
            access(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                   $urandom, 1'($urandom_range(0, 1)));
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
